// File: rtl/l2_arbiter_2port_pkg.sv
// Shared types and constants for the two-port L2 arbiter.
// Holds the FSM state encoding, port identifiers and the round-robin pick.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEFAULT_CNT_WIDTH = 16;

    // Only meaningful when at least one request is high; on a tie the port
    // that did not win last time is chosen.
    function automatic logic pick_port(input logic req0,
                                       input logic req1,
                                       input logic last_grant);
        logic port;
        if (req0 && req1) begin
            port = (last_grant == PORT0) ? PORT1 : PORT0;
        end else if (req1) begin
            port = PORT1;
        end else begin
            port = PORT0;
        end
        return port;
    endfunction

endpackage

// File: rtl/l2_arbiter_2port_if.sv
// Requester and L2 handshake bundle for the two-port L2 arbiter.
// The arbiter takes the slave view; requesters plus the L2 take the master view.
interface l2_arbiter_2port_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_hit;
    logic                  l2_read;
    logic [ADDR_WIDTH-1:0] l2_addr;
    logic                  l2_hit;
    logic [DATA_WIDTH-1:0] l2_rdata;

    modport slave (
        input  req0, addr0, req1, addr1, l2_hit, l2_rdata,
        output ack0, ack1, resp_data, resp_hit, l2_read, l2_addr
    );

    modport master (
        output req0, addr0, req1, addr1, l2_hit, l2_rdata,
        input  ack0, ack1, resp_data, resp_hit, l2_read, l2_addr
    );
endinterface

// File: rtl/l2_arbiter_2port_sat_counter.sv
// Saturating statistics counter; a clear in the same cycle as an
// increment wins and leaves the count at zero.
module sat_counter
    import l2_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register: reset, clear, saturating increment, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/l2_arbiter_2port.sv
// Round-robin arbiter sharing one L2 read port between the L1 I-side (port 0)
// and D-side (port 1) miss paths, with saturating per-port hit/miss counters.
module l2_arbiter_2port
    import l2_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_arbiter_2port_if.slave    bus,
    input  logic                 stats_clr,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] hit_cnt0,
    output logic [CNT_WIDTH-1:0] miss_cnt0,
    output logic [CNT_WIDTH-1:0] hit_cnt1,
    output logic [CNT_WIDTH-1:0] miss_cnt1
);
    arb_state_t            state_r;
    arb_state_t            next_state_s;
    logic                  grant_r;
    logic                  last_grant_r;
    logic                  req_any_s;
    logic                  pick_s;
    logic                  l2_read_r;
    logic                  busy_r;
    logic                  ack0_r;
    logic                  ack1_r;
    logic [ADDR_WIDTH-1:0] l2_addr_r;
    logic [DATA_WIDTH-1:0] resp_data_r;
    logic                  resp_hit_r;
    logic                  inc_hit0_s;
    logic                  inc_miss0_s;
    logic                  inc_hit1_s;
    logic                  inc_miss1_s;

    // Next-state logic and the arbitration decision.
    always_comb begin
        next_state_s = state_r;
        req_any_s    = bus.req0 | bus.req1;
        pick_s       = pick_port(bus.req0, bus.req1, last_grant_r);
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE:   next_state_s = WAIT;
            WAIT:    next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Counter increments happen on the WAIT cycle, when the L2 result is valid.
    always_comb begin
        inc_hit0_s  = 1'b0;
        inc_miss0_s = 1'b0;
        inc_hit1_s  = 1'b0;
        inc_miss1_s = 1'b0;
        if (state_r == WAIT) begin
            inc_hit0_s  = (grant_r == PORT0) &&  bus.l2_hit;
            inc_miss0_s = (grant_r == PORT0) && !bus.l2_hit;
            inc_hit1_s  = (grant_r == PORT1) &&  bus.l2_hit;
            inc_miss1_s = (grant_r == PORT1) && !bus.l2_hit;
        end else begin
            inc_hit0_s  = 1'b0;
            inc_miss0_s = 1'b0;
            inc_hit1_s  = 1'b0;
            inc_miss1_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs, grant bookkeeping and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r      <= PORT0;
            last_grant_r <= PORT1;
            l2_read_r    <= 1'b0;
            busy_r       <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            l2_addr_r    <= '0;
            resp_data_r  <= '0;
            resp_hit_r   <= 1'b0;
        end else begin
            l2_read_r <= (next_state_s == ISSUE);
            busy_r    <= (next_state_s != IDLE);
            ack0_r    <= (state_r == WAIT) && (grant_r == PORT0);
            ack1_r    <= (state_r == WAIT) && (grant_r == PORT1);
            if ((state_r == IDLE) && req_any_s) begin
                grant_r      <= pick_s;
                last_grant_r <= pick_s;
                l2_addr_r    <= (pick_s == PORT1) ? bus.addr1 : bus.addr0;
            end
            if (state_r == WAIT) begin
                resp_data_r <= bus.l2_rdata;
                resp_hit_r  <= bus.l2_hit;
            end
        end
    end

    assign bus.l2_read   = l2_read_r;
    assign bus.l2_addr   = l2_addr_r;
    assign bus.ack0      = ack0_r;
    assign bus.ack1      = ack1_r;
    assign bus.resp_data = resp_data_r;
    assign bus.resp_hit  = resp_hit_r;
    assign busy          = busy_r;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit0 (
        .clk(clk), .rst(rst), .clr(stats_clr), .inc(inc_hit0_s), .count(hit_cnt0)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss0 (
        .clk(clk), .rst(rst), .clr(stats_clr), .inc(inc_miss0_s), .count(miss_cnt0)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit1 (
        .clk(clk), .rst(rst), .clr(stats_clr), .inc(inc_hit1_s), .count(hit_cnt1)
    );
    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss1 (
        .clk(clk), .rst(rst), .clr(stats_clr), .inc(inc_miss1_s), .count(miss_cnt1)
    );
endmodule
